ivs_dma_rd_ctrl: RTL and testbench
==================================

Name: ivs_dma_rd_ctrl

Overview:
AXI read-channel sequencer for the IVS DMA path. It takes a start command, a byte address and a beat count from the AHB-side config registers. It splits the transfer into INCR bursts of 128-bit beats that never cross a 4 KB boundary, and drives AR. It forwards R beats to a downstream valid/ready stream and reports done, error and abort status. One burst is outstanding at a time.

Parameters:
MAX_BURST, 16, max beats per burst; power of 2, range 1..64 (arlen is 6 bits).
AXI_ID, 4'd0, constant value driven on arid; expected value on rid.

Ports:
aclk  in  1  clock.
arst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle command pulse; honoured only in IDLE.
abort  in  1  single-cycle pulse; stops further bursts.
cfg_addr  in  32  start byte address; bits [3:0] ignored (forced 0).
cfg_len  in  16  total beats; 0 means no transfer.
busy  out  1  high while a command is active.
done  out  1  single-cycle completion pulse.
done_abort  out  1  high with done when the command ended by abort.
err  out  1  sticky error flag; cleared by an accepted start.
arvalid  out  1  AR valid.
arready  in  1  AR ready.
arid  out  4  fixed at AXI_ID.
araddr  out  32  burst address.
arlen  out  6  beats-1.
arsize  out  3  constant 3'b100.
arburst  out  2  constant 2'b01.
arlock, arcache, arport, arregion, arqos, aruser  out  1/4/3/4/4/8  constant 0.
rvalid  in  1  R valid.
rready  out  1  R ready.
rid  in  4  R id.
rdata  in  128  R data.
rlast  in  1  R last.
rresp  in  2  R response.
dout_vld  out  1  stream valid.
dout_rdy  in  1  stream ready.
dout_data  out  128  stream data.
dout_last  out  1  final beat of the whole command.

Behaviour:
- Reset (async, arst_n=0): state IDLE. arvalid, araddr, arlen, busy, done, done_abort, err, rready and dout_vld all 0. Counters 0. Reset mid-transfer abandons the command with no done.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - start=1 latches cur_addr={cfg_addr[31:4],4'h0} and remaining=cfg_len, and clears err and done_abort. busy=1 from the next cycle.
  - If cfg_len==0, go to DONE; otherwise go to ADDR.
  - start is ignored while busy.
- Burst size: burst = min(remaining, MAX_BURST, 256 - cur_addr[11:4]). It is computed when ADDR is entered, registered, and presented as arlen=burst-1.
- ADDR:
  - arvalid=1 and araddr=cur_addr; both are registered and held stable until arready.
  - The first arvalid appears the cycle after start.
  - On the arvalid&&arready cycle: cur_addr += burst*16, remaining -= burst, beat_cnt = burst. Next state is DATA and arvalid drops.
- DATA:
  - rready = dout_rdy; dout_vld = rvalid; dout_data = rdata. These are combinational pass-through; no beat is buffered or dropped.
  - dout_last = rvalid && beat_cnt==1 && remaining==0 && !abort_pend.
  - Each rvalid&&rready beat decrements beat_cnt.
  - err is set if rresp!=0, rid!=AXI_ID, rlast=1 with beat_cnt!=1, or rlast=0 with beat_cnt==1.
  - The burst ends when beat_cnt reaches 0, regardless of rlast. Next state is DONE if remaining==0 or abort_pend; otherwise ADDR.
  - rready=0 outside DATA.
- DONE: done=1 for one cycle; done_abort=abort_pend; busy=0 on the next cycle; then IDLE.
- abort:
  - In ADDR or DATA it sets abort_pend.
  - arvalid is never withdrawn once asserted; the in-flight burst is completed and drained.
  - No new AR is issued after abort.
  - abort in IDLE or DONE is ignored. abort_pend clears on entry to IDLE.
  - abort and start in the same IDLE cycle: start wins; abort is ignored.
- Arithmetic: remaining is 16 bits, beat_cnt is 7 bits, cur_addr wraps modulo 2^32 with no error.

Test Plan:
- cfg_addr=0x1000, len=40, MAX_BURST=16 -> AR (0x1000, arlen 15), (0x1100, 15), (0x1200, 7). 40 dout beats; dout_last only on beat 40; one done, done_abort=0, err=0.
- cfg_addr=0x0FC0, len=8 -> AR (0x0FC0, arlen 3) then (0x1000, arlen 3); no 4 KB crossing.
- cfg_len=0 -> no arvalid; done one cycle after the FSM leaves IDLE; busy high for 2 cycles.
- arready held low 5 cycles and dout_rdy toggled randomly -> araddr/arlen stable while arvalid; rready mirrors dout_rdy; dout sequence equals R sequence.
- rresp=2'b10 on beat 3 of len=16 -> all 16 beats forwarded, err=1 at done; next start clears err.
- abort on beat 5 of burst 1 (len=40) -> remaining 11 beats drained, no second AR, done with done_abort=1, no dout_last. arst_n pulse mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/ivs_dma_rd_ctrl.sv
// AXI read-channel sequencer for the IVS DMA path.
// Splits a command into 4 KB-safe INCR bursts and streams R beats out.
module ivs_dma_rd_ctrl #(
    parameter int         MAX_BURST = 16,
    parameter logic [3:0] AXI_ID    = 4'd0
) (
    input  logic         aclk,
    input  logic         arst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [31:0]  cfg_addr,
    input  logic [15:0]  cfg_len,
    output logic         busy,
    output logic         done,
    output logic         done_abort,
    output logic         err,
    output logic         arvalid,
    input  logic         arready,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [5:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arlock,
    output logic [3:0]   arcache,
    output logic [2:0]   arport,
    output logic [3:0]   arregion,
    output logic [3:0]   arqos,
    output logic [7:0]   aruser,
    input  logic         rvalid,
    output logic         rready,
    input  logic [3:0]   rid,
    input  logic [127:0] rdata,
    input  logic         rlast,
    input  logic [1:0]   rresp,
    output logic         dout_vld,
    input  logic         dout_rdy,
    output logic [127:0] dout_data,
    output logic         dout_last
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    localparam logic [16:0] MAX_B = 17'(MAX_BURST);

    state_t      state, state_nxt;
    logic [31:0] cur_addr;
    logic [15:0] remaining;
    logic [6:0]  beat_cnt;
    logic [6:0]  burst;
    logic        abort_pend;

    logic        go;
    logic        ar_hs;
    logic        r_hs;
    logic [31:0] entry_addr;
    logic [15:0] entry_rem;
    logic [16:0] page_lim;
    logic [16:0] burst_lim;
    logic [6:0]  burst_nxt;
    logic        unused_ok;

    assign arid     = AXI_ID;
    assign arsize   = 3'b100;
    assign arburst  = 2'b01;
    assign arlock   = 1'b0;
    assign arcache  = 4'd0;
    assign arport   = 3'd0;
    assign arregion = 4'd0;
    assign arqos    = 4'd0;
    assign aruser   = 8'd0;

    assign go        = (state == IDLE) && start && !busy;
    assign ar_hs     = arvalid && arready;
    assign rready    = (state == DATA) && dout_rdy;
    assign dout_vld  = (state == DATA) && rvalid;
    assign dout_data = rdata;
    assign r_hs      = dout_vld && rready;
    assign dout_last = dout_vld && (beat_cnt == 7'd1)
                     && (remaining == 16'd0) && !abort_pend;
    assign burst_nxt = burst_lim[6:0];
    assign unused_ok = ^{cfg_addr[3:0], burst_lim[16:7]};

    // Next burst size: limited by beats left, MAX_BURST and the 4 KB page end
    always_comb begin
        entry_addr = cur_addr;
        entry_rem  = remaining;
        if (state == IDLE) begin
            entry_addr = {cfg_addr[31:4], 4'h0};
            entry_rem  = cfg_len;
        end
        page_lim  = 17'd256 - {9'd0, entry_addr[11:4]};
        burst_lim = {1'b0, entry_rem};
        if (burst_lim > MAX_B) burst_lim = MAX_B;
        if (burst_lim > page_lim) burst_lim = page_lim;
    end

    // State register
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (go) state_nxt = (cfg_len == 16'd0) ? DONE : ADDR;
            end
            ADDR: begin
                if (ar_hs) state_nxt = DATA;
            end
            DATA: begin
                if (r_hs && beat_cnt == 7'd1) begin
                    if (remaining == 16'd0 || abort_pend || abort)
                        state_nxt = DONE;
                    else
                        state_nxt = ADDR;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command, burst bookkeeping and status registers
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            cur_addr   <= '0;
            remaining  <= '0;
            beat_cnt   <= '0;
            burst      <= '0;
            abort_pend <= 1'b0;
            arvalid    <= 1'b0;
            araddr     <= '0;
            arlen      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_abort <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (done) busy <= 1'b0;
            if (go) begin
                cur_addr   <= {cfg_addr[31:4], 4'h0};
                remaining  <= cfg_len;
                err        <= 1'b0;
                done_abort <= 1'b0;
                busy       <= 1'b1;
            end
            if (state != ADDR && state_nxt == ADDR) begin
                arvalid <= 1'b1;
                araddr  <= entry_addr;
                burst   <= burst_nxt;
                arlen   <= 6'(burst_nxt - 7'd1);
            end
            if (ar_hs) begin
                arvalid   <= 1'b0;
                cur_addr  <= cur_addr + {21'd0, burst, 4'h0};
                remaining <= remaining - {9'd0, burst};
                beat_cnt  <= burst;
            end
            if (r_hs) begin
                beat_cnt <= beat_cnt - 7'd1;
                if (rresp != 2'b00 || rid != AXI_ID
                    || (rlast != (beat_cnt == 7'd1)))
                    err <= 1'b1;
            end
            if (abort && (state == ADDR || state == DATA))
                abort_pend <= 1'b1;
            if (state == DONE) begin
                done_abort <= abort_pend;
                abort_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ivs_dma_rd_ctrl.sv
// Directed bench for ivs_dma_rd_ctrl.
// Acts as AXI slave and stream sink, checking AR and R/stream behaviour.
module tb_ivs_dma_rd_ctrl;

    logic         aclk = 1'b0;
    logic         arst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [31:0]  cfg_addr = '0;
    logic [15:0]  cfg_len = '0;
    logic         busy, done, done_abort, err;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [5:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arlock;
    logic [3:0]   arcache;
    logic [2:0]   arport;
    logic [3:0]   arregion;
    logic [3:0]   arqos;
    logic [7:0]   aruser;
    logic         rvalid = 1'b0;
    logic         rready;
    logic [3:0]   rid = 4'd0;
    logic [127:0] rdata = '0;
    logic         rlast = 1'b0;
    logic [1:0]   rresp = 2'b00;
    logic         dout_vld;
    logic         dout_rdy = 1'b0;
    logic [127:0] dout_data;
    logic         dout_last;

    int total = 0;
    int bad = 0;

    ivs_dma_rd_ctrl #(.MAX_BURST(16), .AXI_ID(4'd0)) dut (
        .aclk(aclk), .arst_n(arst_n), .start(start), .abort(abort),
        .cfg_addr(cfg_addr), .cfg_len(cfg_len), .busy(busy),
        .done(done), .done_abort(done_abort), .err(err),
        .arvalid(arvalid), .arready(arready), .arid(arid),
        .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arport(arport), .arregion(arregion), .arqos(arqos),
        .aruser(aruser), .rvalid(rvalid), .rready(rready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rresp(rresp),
        .dout_vld(dout_vld), .dout_rdy(dout_rdy),
        .dout_data(dout_data), .dout_last(dout_last)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_cmd(input logic [31:0] a, input logic [15:0] n,
                             input bit ab);
        @(negedge aclk);
        cfg_addr = a;
        cfg_len  = n;
        start    = 1'b1;
        abort    = ab;
        @(negedge aclk);
        start = 1'b0;
        abort = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic do_ar(input logic [31:0] ea, input logic [5:0] el,
                         input int dly);
        int n = 0;
        while (!arvalid && n < 40) begin
            @(negedge aclk);
            n++;
        end
        check("ar_seen", arvalid, 1);
        for (int k = 0; k < dly; k++) begin
            arready = 1'b0;
            check("ar_hold_addr", araddr, ea);
            check("ar_hold_len", arlen, el);
            @(negedge aclk);
            check("ar_hold_vld", arvalid, 1);
        end
        check("ar_addr", araddr, ea);
        check("ar_len", arlen, el);
        check("rready_in_addr", rready, 0);
        arready = 1'b1;
        @(negedge aclk);
        arready = 1'b0;
        check("ar_drop", arvalid, 0);
    endtask

    task automatic r_burst(input int n, input int base, input int tot,
                           input bit tog, input int err_beat,
                           input int abort_beat, input bit no_last);
        for (int i = 0; i < n; i++) begin
            int gi;
            int tries;
            bit took;
            logic [127:0] d;
            gi = base + i;
            tries = 0;
            d = {32'hCAFE0000 + 32'(gi), 32'h12345678,
                 ~32'(gi), 32'(gi)};
            do begin
                rvalid = 1'b1;
                rdata  = d;
                rlast  = (i == n - 1);
                rresp  = (i == err_beat) ? 2'b10 : 2'b00;
                abort  = (i == abort_beat) && (tries == 0);
                if (tog && tries < 6)
                    dout_rdy = 1'($urandom_range(0, 1));
                else
                    dout_rdy = 1'b1;
                took = dout_rdy;
                #1;
                check("dout_vld", dout_vld, 1);
                check("dout_data", dout_data, d);
                check("rready", rready, took);
                check("dout_last", dout_last,
                      (!no_last && gi == tot - 1));
                tries++;
                @(negedge aclk);
                abort = 1'b0;
            end while (!took);
        end
        rvalid   = 1'b0;
        rlast    = 1'b0;
        rresp    = 2'b00;
        dout_rdy = 1'b0;
    endtask

    task automatic wait_done(input bit exp_ab, input bit exp_err);
        int n = 0;
        while (!done && n < 20) begin
            check("no_ar_at_end", arvalid, 0);
            @(negedge aclk);
            n++;
        end
        check("done_seen", done, 1);
        check("done_abort", done_abort, exp_ab);
        check("err_at_done", err, exp_err);
        check("busy_with_done", busy, 1);
        @(negedge aclk);
        check("done_pulse", done, 0);
        check("busy_clear", busy, 0);
    endtask

    initial begin
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_abort", done_abort, 0);
        check("rst_err", err, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_araddr", araddr, 0);
        check("rst_arlen", arlen, 0);
        check("rst_rready", rready, 0);
        check("rst_dout_vld", dout_vld, 0);
        check("arsize", arsize, 3'b100);
        check("arburst", arburst, 2'b01);
        check("arid", arid, 4'd0);
        @(negedge aclk);
        arst_n = 1'b1;

        // 40 beats from 0x1000: bursts of 16, 16, 8
        start_cmd(32'h0000_1000, 16'd40, 1'b0);
        check("ar_first_cycle", arvalid, 1);
        do_ar(32'h0000_1000, 6'd15, 0);
        r_burst(16, 0, 40, 1'b0, -1, -1, 1'b0);
        do_ar(32'h0000_1100, 6'd15, 0);
        r_burst(16, 16, 40, 1'b0, -1, -1, 1'b0);
        do_ar(32'h0000_1200, 6'd7, 0);
        r_burst(8, 32, 40, 1'b0, -1, -1, 1'b0);
        wait_done(1'b0, 1'b0);

        // 4 KB page split; low address bits ignored
        start_cmd(32'h0000_0FC7, 16'd8, 1'b0);
        do_ar(32'h0000_0FC0, 6'd3, 0);
        r_burst(4, 0, 8, 1'b0, -1, -1, 1'b0);
        do_ar(32'h0000_1000, 6'd3, 0);
        r_burst(4, 4, 8, 1'b0, -1, -1, 1'b0);
        wait_done(1'b0, 1'b0);

        // zero-length command
        start_cmd(32'h0000_2000, 16'd0, 1'b0);
        check("z_no_ar", arvalid, 0);
        check("z_no_done_yet", done, 0);
        @(negedge aclk);
        check("z_done", done, 1);
        check("z_busy2", busy, 1);
        check("z_no_ar2", arvalid, 0);
        @(negedge aclk);
        check("z_done_off", done, 0);
        check("z_busy_off", busy, 0);

        // AR backpressure and random stream backpressure
        start_cmd(32'h0000_3000, 16'd20, 1'b0);
        do_ar(32'h0000_3000, 6'd15, 5);
        r_burst(16, 0, 20, 1'b1, -1, -1, 1'b0);
        do_ar(32'h0000_3100, 6'd3, 5);
        r_burst(4, 16, 20, 1'b1, -1, -1, 1'b0);
        wait_done(1'b0, 1'b0);

        // SLVERR on beat 3; err sticky until next start
        start_cmd(32'h0000_4000, 16'd16, 1'b0);
        do_ar(32'h0000_4000, 6'd15, 0);
        r_burst(16, 0, 16, 1'b0, 2, -1, 1'b0);
        wait_done(1'b0, 1'b1);
        @(negedge aclk);
        check("err_sticky", err, 1);
        start_cmd(32'h0000_4000, 16'd0, 1'b0);
        check("err_cleared", err, 0);
        @(negedge aclk);
        check("z2_done", done, 1);
        @(negedge aclk);
        check("z2_busy_off", busy, 0);

        // abort on beat 5 of burst 1: drain, no second AR
        start_cmd(32'h0000_6000, 16'd40, 1'b0);
        do_ar(32'h0000_6000, 6'd15, 0);
        r_burst(16, 0, 40, 1'b0, -1, 4, 1'b1);
        wait_done(1'b1, 1'b0);

        // start and abort together: start wins
        start_cmd(32'h0000_7000, 16'd4, 1'b1);
        do_ar(32'h0000_7000, 6'd3, 0);
        r_burst(4, 0, 4, 1'b0, -1, -1, 1'b0);
        wait_done(1'b0, 1'b0);

        // reset in the middle of a burst
        start_cmd(32'h0000_5000, 16'd40, 1'b0);
        do_ar(32'h0000_5000, 6'd15, 0);
        rvalid   = 1'b1;
        dout_rdy = 1'b1;
        repeat (3) @(negedge aclk);
        arst_n = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_arvalid", arvalid, 0);
        check("mrst_araddr", araddr, 0);
        check("mrst_arlen", arlen, 0);
        check("mrst_rready", rready, 0);
        check("mrst_dout_vld", dout_vld, 0);
        check("mrst_dout_last", dout_last, 0);
        @(negedge aclk);
        arst_n   = 1'b1;
        rvalid   = 1'b0;
        dout_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            check("mrst_no_done", done, 0);
            check("mrst_idle", busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
